note_sequencer: RTL and testbench

Record-and-playback scheduler sitting between `convert_keyboard_input` and the `datapath`/`audio3` frequency path. In record mode it captures keyboard make/break events as a list of {note, octave, duration} entries. In play mode it replays them in order, driving note/octave and a sounding flag at tempo-tick resolution. It owns sequencing only; frequency lookup and VGA drawing stay in `datapath`.

---
 rtl/note_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_note_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
// Record-and-playback scheduler for keyboard note events. In REC it captures
// make/break events as {note, octave, duration-in-ticks} entries. In PLAY it
// replays them in order, one tempo tick of silence after each note.
//
// Ports:
//   clk, reset (async, active-high)
//   rec_en                      level, selects record mode from IDLE
//   key_valid/key_make          keyboard event strobe and press/release flag
//   key_note/key_octave         note code / octave of the event
//   play_start/play_stop        playback control pulses (stop wins)
//   play_note/play_octave       note currently being driven
//   play_active                 high while a note sounds
//   state                       00 IDLE, 01 REC, 10 PLAY
//   count/full                  stored entry count, count == DEPTH
//   done                        one-cycle pulse at end of playback
//
// Build option: define NOTE_SEQUENCER_LOOP_EN to repeat playback from entry 0
// instead of pulsing done after the last entry.
// ---------------------------------------------------------------------------
module note_sequencer #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 500000,
  parameter int DUR_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rec_en,
  input  logic                     key_valid,
  input  logic                     key_make,
  input  logic [3:0]               key_note,
  input  logic [1:0]               key_octave,
  input  logic                     play_start,
  input  logic                     play_stop,
  output logic [3:0]               play_note,
  output logic [1:0]               play_octave,
  output logic                     play_active,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     done
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REC  = 2'b01,
    ST_PLAY = 2'b10
  } state_t;

  typedef struct packed {
    logic [3:0]       note;
    logic [1:0]       octave;
    logic [DUR_W-1:0] dur;
  } entry_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               done_q, done_d;
  logic [3:0]         play_note_q, play_note_d;
  logic [1:0]         play_octave_q, play_octave_d;
  logic               play_active_q, play_active_d;
  logic               held_q, held_d;
  logic [3:0]         hold_note_q, hold_note_d;
  logic [1:0]         hold_oct_q, hold_oct_d;
  logic [DUR_W-1:0]   hold_dur_q, hold_dur_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DUR_W-1:0]   rem_q, rem_d;
  logic               gap_q, gap_d;
  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];

  logic               tick_wrap;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   nxt;
  logic               started;
  logic               load;
  entry_t             ent;

  assign tick_wrap = (tick_q == TICK_W'(TICK_DIV - 1));

  always_comb begin
    state_d       = state_q;
    tick_d        = tick_wrap ? '0 : tick_q + TICK_W'(1);
    count_d       = count_q;
    full_d        = full_q;
    done_d        = 1'b0;
    play_note_d   = play_note_q;
    play_octave_d = play_octave_q;
    play_active_d = play_active_q;
    held_d        = held_q;
    hold_note_d   = hold_note_q;
    hold_oct_d    = hold_oct_q;
    hold_dur_d    = hold_dur_q;
    idx_d         = idx_q;
    rem_d         = rem_q;
    gap_d         = gap_q;
    mem_d         = mem_q;
    cnt           = count_q;
    nxt           = {1'b0, idx_q} + CNT_W'(1);
    started       = 1'b0;
    load          = 1'b0;
    ent           = mem_q[0];

    case (state_q)
      ST_IDLE: begin
        tick_d        = '0;
        play_active_d = 1'b0;
        if (rec_en) begin
          state_d = ST_REC;
          count_d = '0;
          full_d  = 1'b0;
          held_d  = 1'b0;
        end else if (play_start && !play_stop) begin
          if (count_q != '0) begin
            state_d = ST_PLAY;
            idx_d   = '0;
            load    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_REC: begin
        if (held_q && tick_wrap && hold_dur_q != '1)
          hold_dur_d = hold_dur_q + DUR_W'(1);
        if (key_valid && !full_q) begin
          if (key_make) begin
            // A new press while holding closes the old note first.
            if (held_q) begin
              mem_d[cnt[IDX_W-1:0]] = {hold_note_q, hold_oct_q, hold_dur_q};
              cnt = cnt + CNT_W'(1);
            end
            started     = 1'b1;
            held_d      = 1'b1;
            hold_note_d = key_note;
            hold_oct_d  = key_octave;
            hold_dur_d  = DUR_W'(1);
            tick_d      = '0;
          end else if (held_q && key_note == hold_note_q && key_octave == hold_oct_q) begin
            mem_d[cnt[IDX_W-1:0]] = {hold_note_q, hold_oct_q, hold_dur_q};
            cnt    = cnt + CNT_W'(1);
            held_d = 1'b0;
          end
        end
        // Leaving REC flushes a still-held note with the duration it has so
        // far, matching what a break in this cycle would have stored.
        if (!rec_en) begin
          if (held_d && cnt != CNT_W'(DEPTH)) begin
            mem_d[cnt[IDX_W-1:0]] = {hold_note_d, hold_oct_d,
                                     started ? DUR_W'(1) : hold_dur_q};
            cnt = cnt + CNT_W'(1);
          end
          held_d  = 1'b0;
          state_d = ST_IDLE;
          tick_d  = '0;
        end
        count_d = cnt;
        full_d  = (cnt == CNT_W'(DEPTH));
      end

      ST_PLAY: begin
        if (play_stop) begin
          state_d       = ST_IDLE;
          play_active_d = 1'b0;
          tick_d        = '0;
        end else if (tick_wrap) begin
          if (!gap_q) begin
            if (rem_q <= DUR_W'(1)) begin
              gap_d         = 1'b1;
              play_active_d = 1'b0;
            end else begin
              rem_d = rem_q - DUR_W'(1);
            end
          end else if (nxt == count_q) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
            idx_d = '0;
            load  = 1'b1;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d = nxt[IDX_W-1:0];
            load  = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      ent           = mem_q[idx_d];
      play_note_d   = ent.note;
      play_octave_d = ent.octave;
      rem_d         = ent.dur;
      gap_d         = 1'b0;
      play_active_d = 1'b1;
      tick_d        = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tick_q        <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      done_q        <= 1'b0;
      play_note_q   <= '0;
      play_octave_q <= '0;
      play_active_q <= 1'b0;
      held_q        <= 1'b0;
      hold_note_q   <= '0;
      hold_oct_q    <= '0;
      hold_dur_q    <= '0;
      idx_q         <= '0;
      rem_q         <= '0;
      gap_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      count_q       <= count_d;
      full_q        <= full_d;
      done_q        <= done_d;
      play_note_q   <= play_note_d;
      play_octave_q <= play_octave_d;
      play_active_q <= play_active_d;
      held_q        <= held_d;
      hold_note_q   <= hold_note_d;
      hold_oct_q    <= hold_oct_d;
      hold_dur_q    <= hold_dur_d;
      idx_q         <= idx_d;
      rem_q         <= rem_d;
      gap_q         <= gap_d;
    end
  end

  // Entry storage is not reset; count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign play_note   = play_note_q;
  assign play_octave = play_octave_q;
  assign play_active = play_active_q;
  assign state       = state_q;
  assign count       = count_q;
  assign full        = full_q;
  assign done        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with DEPTH = 4, TICK_DIV = 4. Playback is checked
// cycle by cycle against a timeline expanded from a list of expected entries.
module tb_note_sequencer;
  localparam int DEPTH = 4;
  localparam int TICK  = 4;
  localparam int DUR_W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rec_en = 1'b0;
  logic       key_valid = 1'b0;
  logic       key_make = 1'b0;
  logic [3:0] key_note = '0;
  logic [1:0] key_octave = '0;
  logic       play_start = 1'b0;
  logic       play_stop = 1'b0;
  logic [3:0] play_note;
  logic [1:0] play_octave;
  logic       play_active;
  logic [1:0] state;
  logic [2:0] count;
  logic       full;
  logic       done;

  note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK), .DUR_W(DUR_W)) dut (
    .clk(clk), .reset(reset), .rec_en(rec_en), .key_valid(key_valid),
    .key_make(key_make), .key_note(key_note), .key_octave(key_octave),
    .play_start(play_start), .play_stop(play_stop), .play_note(play_note),
    .play_octave(play_octave), .play_active(play_active), .state(state),
    .count(count), .full(full), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] note;
    logic [1:0] oct;
    int         dur;
  } ent_t;

  typedef struct {
    logic [3:0] note;
    logic [1:0] oct;
    int         hold;
    int         exp_dur;
  } vec_t;

  ent_t exp_q[$];
  vec_t tbl[3];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [9:0] M_ALL = 10'b11_1_1111_11_1;
  localparam logic [9:0] M_GAP = 10'b11_1_0000_00_1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {state, play_active, play_note, play_octave, done}
  task automatic chk_m(input string name, input logic [9:0] exp, input logic [9:0] mask);
    logic [9:0] act;
    act = {state, play_active, play_note, play_octave, done};
    n_cmp++;
    if ((act & mask) !== (exp & mask)) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (mask %b)", name, act, exp, mask);
    end
  endtask

  function automatic int model_dur(input int hold);
    int d;
    d = 1 + (hold - 1) / TICK;
    return (d > 255) ? 255 : d;
  endfunction

  function automatic ent_t mk(input logic [3:0] n, input logic [1:0] o, input int d);
    ent_t e;
    e.note = n;
    e.oct  = o;
    e.dur  = d;
    return e;
  endfunction

  // hold = cycles from the make edge to the break edge.
  task automatic record_note(input logic [3:0] n, input logic [1:0] o,
                             input int hold, input bit bogus);
    key_valid = 1'b1; key_make = 1'b1; key_note = n; key_octave = o;
    step();
    key_valid = 1'b0;
    if (bogus) begin
      key_valid = 1'b1; key_make = 1'b0; key_note = n + 4'd1;
      step();
      key_valid = 1'b0;
      repeat (hold - 2) step();
    end else begin
      repeat (hold - 1) step();
    end
    key_valid = 1'b1; key_make = 1'b0; key_note = n; key_octave = o;
    step();
    key_valid = 1'b0;
  endtask

  task automatic play_check(input string tag);
    int passes;
`ifdef NOTE_SEQUENCER_LOOP_EN
    passes = 3;
`else
    passes = 1;
`endif
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        for (int c = 0; c < exp_q[i].dur * TICK; c++) begin
          chk_m({tag, "_note"}, {2'b10, 1'b1, exp_q[i].note, exp_q[i].oct, 1'b0}, M_ALL);
          step();
        end
        for (int c = 0; c < TICK; c++) begin
          chk_m({tag, "_gap"}, {2'b10, 1'b0, 4'h0, 2'b00, 1'b0}, M_GAP);
          step();
        end
      end
    end
`ifdef NOTE_SEQUENCER_LOOP_EN
    chk_m({tag, "_loop"}, {2'b10, 1'b1, exp_q[0].note, exp_q[0].oct, 1'b0}, M_ALL);
    play_stop = 1'b1;
    step();
    play_stop = 1'b0;
    chk_m({tag, "_stop"}, {2'b00, 1'b0, 4'h0, 2'b00, 1'b0}, M_GAP);
    step();
`else
    chk_m({tag, "_done"}, {2'b00, 1'b0, 4'h0, 2'b00, 1'b1}, M_GAP);
    step();
    chk_m({tag, "_done_off"}, {2'b00, 1'b0, 4'h0, 2'b00, 1'b0}, M_GAP);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{note: 4'd1, oct: 2'd0, hold: 8,  exp_dur: 2};
    tbl[1] = '{note: 4'd2, oct: 2'd1, hold: 4,  exp_dur: 1};
    tbl[2] = '{note: 4'd3, oct: 2'd2, hold: 16, exp_dur: 4};

    // Reset and idle
    repeat (3) step();
    chk_m("in_reset", 10'd0, M_ALL);
    chk("in_reset_count", count, 0);
    reset = 1'b0;
    repeat (20) step();
    chk_m("idle", 10'd0, M_ALL);
    chk("idle_count", count, 0);
    chk("idle_full", full, 0);
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    chk_m("empty_play_done", {2'b00, 1'b0, 4'h0, 2'b00, 1'b1}, M_GAP);
    step();
    chk_m("empty_play_done_off", 10'd0, M_GAP);

    // Single note, held 10 cycles -> dur 3
    rec_en = 1'b1;
    step();
    chk("rec_state", state, 2'b01);
    record_note(4'd5, 2'd2, 10, 1'b0);
    chk("single_count", count, 1);
    rec_en = 1'b0;
    step();
    chk("single_exit_state", state, 2'b00);
    exp_q.delete();
    exp_q.push_back(mk(4'd5, 2'd2, 3));
    play_check("single");

    // Table-driven three-note recording
    rec_en = 1'b1;
    step();
    chk("table_count_clr", count, 0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      record_note(tbl[i].note, tbl[i].oct, tbl[i].hold, 1'b0);
      chk("table_count", count, i + 1);
      exp_q.push_back(mk(tbl[i].note, tbl[i].oct, tbl[i].exp_dur));
      step();
    end
    rec_en = 1'b0;
    step();
    play_check("table");

    // Overfill: fifth pair ignored
    rec_en = 1'b1;
    step();
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      record_note(4'(k + 1), 2'd0, 4, 1'b0);
      if (k < DEPTH) exp_q.push_back(mk(4'(k + 1), 2'd0, 1));
      chk("fill_count", count, exp_q.size());
      chk("fill_full", full, (k >= DEPTH - 1) ? 1 : 0);
      step();
    end
    rec_en = 1'b0;
    step();
    play_check("fill");

    // Start and stop together in IDLE: stop wins
    play_start = 1'b1; play_stop = 1'b1;
    step();
    play_start = 1'b0; play_stop = 1'b0;
    chk_m("idle_startstop", 10'd0, M_GAP);

    // Start and stop together during playback
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    chk_m("stop_running", {2'b10, 1'b1, 4'd1, 2'd0, 1'b0}, M_ALL);
    repeat (5) step();
    play_start = 1'b1; play_stop = 1'b1;
    step();
    play_start = 1'b0; play_stop = 1'b0;
    chk_m("stop_idle", 10'd0, M_GAP);
    step();
    chk_m("stop_no_done", 10'd0, M_GAP);

    // Break coincident with rec_en falling: event stored, then exit
    rec_en = 1'b1;
    step();
    key_valid = 1'b1; key_make = 1'b1; key_note = 4'd7; key_octave = 2'd1;
    step();
    key_valid = 1'b0;
    repeat (6) step();
    key_valid = 1'b1; key_make = 1'b0; rec_en = 1'b0;
    step();
    key_valid = 1'b0;
    chk("brk_exit_count", count, 1);
    chk("brk_exit_state", state, 2'b00);
    exp_q.delete();
    exp_q.push_back(mk(4'd7, 2'd1, model_dur(7)));
    play_check("brk_exit");

    // rec_en falling with a note still held flushes it
    rec_en = 1'b1;
    step();
    key_valid = 1'b1; key_make = 1'b1; key_note = 4'd9; key_octave = 2'd3;
    step();
    key_valid = 1'b0;
    repeat (8) step();
    rec_en = 1'b0;
    step();
    chk("held_exit_count", count, 1);
    exp_q.delete();
    exp_q.push_back(mk(4'd9, 2'd3, model_dur(9)));
    play_check("held_exit");

    // Randomized sessions against the entry-list model
    for (int it = 0; it < 8; it++) begin
      int n;
      rec_en = 1'b1;
      step();
      exp_q.delete();
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        logic [3:0] nn;
        logic [1:0] oo;
        int         h;
        bit         bg;
        nn = 4'($urandom_range(0, 15));
        oo = 2'($urandom_range(0, 3));
        h  = $urandom_range(2, 14);
        bg = 1'($urandom_range(0, 1));
        record_note(nn, oo, h, bg);
        if (exp_q.size() < DEPTH) exp_q.push_back(mk(nn, oo, model_dur(h)));
        chk("rand_count", count, exp_q.size());
        repeat ($urandom_range(0, 3)) step();
      end
      rec_en = 1'b0;
      step();
      play_check("rand");
    end

    // Reset in the middle of a note aborts immediately
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    step();
    chk("pre_reset_active", play_active, 1);
    reset = 1'b1;
    #2;
    chk("reset_active", play_active, 0);
    chk("reset_count", count, 0);
    chk("reset_state", state, 2'b00);
    reset = 1'b0;
    step();
    chk_m("post_reset", 10'd0, M_ALL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
